// File: rtl/gate_route_steer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_route_steer_pkg
// Purpose  : Shared types and constants for the receive-side steering gate:
//            route tag field widths, capability entry layout, FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gate_route_steer_pkg;

  localparam int ROUTE_PORT_BITS = 2;
  localparam int ROUTE_UL_BITS   = 3;

  typedef struct packed {
    logic                     valid;
    logic [ROUTE_UL_BITS-1:0] ul_id;
  } route_cap_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_FWD    = 2'd2,
    ST_DROP   = 2'd3
  } steer_state_t;

endpackage
`default_nettype wire

// File: rtl/gate_route_steer_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_route_steer_if
// Purpose  : AXI4-Stream bundle with a vector valid/ready so one type serves
//            both the single input stream and the N-port steered output.
// Ports    : tvalid/tready [N_VALID], tdata [DATA_BITS], tkeep [DATA_BITS/8],
//            tlast; modports master (source) and slave (sink).
// Revision : 1.0 - initial release
// ============================================================================
interface gate_route_steer_if #(
  parameter int DATA_BITS = 512,
  parameter int N_VALID   = 1
) ();
  logic [N_VALID-1:0]     tvalid;
  logic [N_VALID-1:0]     tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/gate_cap_table.sv
`default_nettype none
// ============================================================================
// Module   : gate_cap_table
// Purpose  : Host-programmed capability register file, one {valid, ul_id}
//            entry per output port, with a combinational lookup-and-match.
// Ports    : aclk, aresetn (sync, active-low), cap_wr_valid, cap_wr_data[7:0],
//            cap_clr, lk_port, lk_ul (lookup key), lk_match (entry hit).
// Revision : 1.0 - initial release
// ============================================================================
module gate_cap_table
  import gate_route_steer_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  wire logic                       aclk,
  input  wire logic                       aresetn,
  input  wire logic                       cap_wr_valid,
  input  wire logic [7:0]                 cap_wr_data,
  input  wire logic                       cap_clr,
  input  wire logic [ROUTE_PORT_BITS-1:0] lk_port,
  input  wire logic [ROUTE_UL_BITS-1:0]   lk_ul,
  output logic                            lk_match
);

  route_cap_t [N_PORTS-1:0] w_tab;

  // Bits [7:5] of the write word carry no meaning for the table.
  logic w_unused_wr_bits;
  assign w_unused_wr_bits = ^cap_wr_data[7:5];

  // An out-of-range write index matches no entry and is silently dropped.
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_entry
      route_cap_t r_entry;
      always_ff @(posedge aclk) begin
        if (!aresetn || cap_clr) begin
          r_entry <= '0;
        end else if (cap_wr_valid && cap_wr_data[1:0] == ROUTE_PORT_BITS'(gi)) begin
          r_entry <= '{valid: 1'b1, ul_id: cap_wr_data[4:2]};
        end
      end
      assign w_tab[gi] = r_entry;
    end
  endgenerate

  // Scan instead of indexing so a port index >= N_PORTS simply never hits.
  always_comb begin
    lk_match = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (lk_port == ROUTE_PORT_BITS'(i) && w_tab[i].valid && w_tab[i].ul_id == lk_ul) begin
        lk_match = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gate_route_steer.sv
`default_nettype none
// ============================================================================
// Module   : gate_route_steer
// Purpose  : Steers each input packet to one of N_PORTS output streams by its
//            route tag, forwarding only if the sender UL id matches the
//            capability entry of the target port; otherwise drops the packet.
// Ports    : aclk, aresetn (sync, active-low); cap_wr_valid/cap_wr_data/
//            cap_clr (capability programming); s_route (route tag);
//            s_axis (input stream, slave); m_axis (N-port output, master);
//            fwd_cnt/drop_cnt (saturating packet counters); busy.
// Revision : 1.0 - initial release
// ============================================================================
module gate_route_steer
  import gate_route_steer_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int DATA_BITS = 512,
  parameter int CNT_BITS  = 32
) (
  input  wire logic                aclk,
  input  wire logic                aresetn,
  input  wire logic                cap_wr_valid,
  input  wire logic [7:0]          cap_wr_data,
  input  wire logic                cap_clr,
  input  wire logic [7:0]          s_route,
  gate_route_steer_if.slave        s_axis,
  gate_route_steer_if.master       m_axis,
  output logic [CNT_BITS-1:0]      fwd_cnt,
  output logic [CNT_BITS-1:0]      drop_cnt,
  output logic                     busy
);

  steer_state_t                          r_state;
  steer_state_t                          w_state_nxt;
  logic [ROUTE_UL_BITS+ROUTE_PORT_BITS-1:0] r_route;
  logic [ROUTE_PORT_BITS-1:0]            r_sel;
  logic [CNT_BITS-1:0]                   r_fwd_cnt;
  logic [CNT_BITS-1:0]                   r_drop_cnt;
  logic                                  w_match;
  logic                                  w_sel_ready;

  logic w_unused_route_bits;
  assign w_unused_route_bits = ^s_route[7:5];

  gate_cap_table #(
    .N_PORTS (N_PORTS)
  ) u_cap_table (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cap_wr_valid (cap_wr_valid),
    .cap_wr_data  (cap_wr_data),
    .cap_clr      (cap_clr),
    .lk_port      (r_route[ROUTE_PORT_BITS-1:0]),
    .lk_ul        (r_route[ROUTE_UL_BITS+ROUTE_PORT_BITS-1:ROUTE_PORT_BITS]),
    .lk_match     (w_match)
  );

  // Ready of the selected downstream port; r_sel is always < N_PORTS in FWD.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_sel == ROUTE_PORT_BITS'(i)) begin
        w_sel_ready = m_axis.tready[i];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_axis.tready = '0;
    m_axis.tvalid = '0;
    case (r_state)
      ST_IDLE: begin
        if (s_axis.tvalid[0]) begin
          w_state_nxt = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        w_state_nxt = w_match ? ST_FWD : ST_DROP;
      end
      ST_FWD: begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (r_sel == ROUTE_PORT_BITS'(i)) begin
            m_axis.tvalid[i] = s_axis.tvalid[0];
          end
        end
        s_axis.tready[0] = w_sel_ready;
        if (s_axis.tvalid[0] && w_sel_ready && s_axis.tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        s_axis.tready[0] = 1'b1;
        if (s_axis.tvalid[0] && s_axis.tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_route    <= '0;
      r_sel      <= '0;
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && s_axis.tvalid[0]) begin
        r_route <= s_route[ROUTE_UL_BITS+ROUTE_PORT_BITS-1:0];
      end
      if (r_state == ST_DECIDE) begin
        if (w_match) begin
          r_sel <= r_route[ROUTE_PORT_BITS-1:0];
          if (r_fwd_cnt != '1) begin
            r_fwd_cnt <= r_fwd_cnt + CNT_BITS'(1);
          end
        end else if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_BITS'(1);
        end
      end
    end
  end

  // Payload is shared by all ports; only the valid vector distinguishes them.
  assign m_axis.tdata = s_axis.tdata;
  assign m_axis.tkeep = s_axis.tkeep;
  assign m_axis.tlast = s_axis.tlast;

  assign fwd_cnt  = r_fwd_cnt;
  assign drop_cnt = r_drop_cnt;
  assign busy     = (r_state == ST_FWD) || (r_state == ST_DROP);

endmodule
`default_nettype wire

// File: tb/tb_gate_route_steer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_route_steer
// Purpose  : Directed self-checking bench for gate_route_steer. Packet-level
//            model (capability table + expected-beat queue) with a per-cycle
//            output monitor; counters use a narrow width to reach saturation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_route_steer;

  localparam int DB   = 512;
  localparam int NP   = 4;
  localparam int CB   = 3;
  localparam int CMAX = (1 << CB) - 1;

  typedef struct {
    logic [DB-1:0] data;
    logic          last;
    logic [1:0]    port;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cap_wr_valid;
  logic [7:0]    cap_wr_data;
  logic          cap_clr;
  logic [7:0]    s_route;
  logic [CB-1:0] fwd_cnt;
  logic [CB-1:0] drop_cnt;
  logic          busy;

  gate_route_steer_if #(.DATA_BITS(DB), .N_VALID(1))  s_if ();
  gate_route_steer_if #(.DATA_BITS(DB), .N_VALID(NP)) m_if ();

  gate_route_steer #(
    .N_PORTS   (NP),
    .DATA_BITS (DB),
    .CNT_BITS  (CB)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cap_wr_valid (cap_wr_valid),
    .cap_wr_data  (cap_wr_data),
    .cap_clr      (cap_clr),
    .s_route      (s_route),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .fwd_cnt      (fwd_cnt),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Model state
  bit         mvalid [NP];
  logic [2:0] mul    [NP];
  int         mfwd   = 0;
  int         mdrop  = 0;
  beat_t      exp_q[$];

  logic [NP-1:0] last_mvalid;
  logic          last_busy;

  task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit model_match(input logic [7:0] r);
    return mvalid[r[1:0]] && (mul[r[1:0]] == r[4:2]);
  endfunction

  task automatic model_cap(input logic [7:0] d, input bit wr, input bit clr);
    if (clr) begin
      for (int i = 0; i < NP; i++) mvalid[i] = 1'b0;
    end else if (wr) begin
      mvalid[d[1:0]] = 1'b1;
      mul[d[1:0]]    = d[4:2];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) mvalid[i] = 1'b0;
    mfwd  = 0;
    mdrop = 0;
    exp_q.delete();
  endtask

  // Monitor: every cycle with an output valid, the beat must be the next
  // expected one on the expected port; a stalled beat must be held unchanged.
  bit            pend = 1'b0;
  logic [NP-1:0] pend_valid;
  logic [DB-1:0] pend_data;

  always @(negedge aclk) begin
    if (pend) begin
      chk("stall_hold_valid", DB'(m_if.tvalid), DB'(pend_valid));
      chk("stall_hold_data", m_if.tdata, pend_data);
    end
    if (m_if.tvalid != '0) begin
      if ($countones(m_if.tvalid) != 1) begin
        chk("onehot_valid", DB'($countones(m_if.tvalid)), DB'(1));
      end else if (exp_q.size() == 0) begin
        chk("unexpected_beat", DB'(m_if.tvalid), DB'(0));
      end else begin
        chk("mon_port", DB'(m_if.tvalid), DB'(4'b0001 << exp_q[0].port));
        chk("mon_data", m_if.tdata, exp_q[0].data);
        chk("mon_last", DB'(m_if.tlast), DB'(exp_q[0].last));
        if ((m_if.tvalid & m_if.tready) != '0) void'(exp_q.pop_front());
      end
    end
    pend       = aresetn && (m_if.tvalid != '0) && ((m_if.tvalid & m_if.tready) == '0);
    pend_valid = m_if.tvalid;
    pend_data  = m_if.tdata;
  end

  task automatic cap_op(input logic [7:0] d, input bit wr, input bit clr);
    cap_wr_valid = wr;
    cap_wr_data  = d;
    cap_clr      = clr;
    @(posedge aclk); #1;
    cap_wr_valid = 1'b0;
    cap_clr      = 1'b0;
    model_cap(d, wr, clr);
  endtask

  // Sends one packet; optionally writes the capability table during the
  // decision cycle (that write must not influence this packet).
  task automatic send_pkt(input logic [7:0] route, input int n, input int base,
                          input bit stall, input bit dec_wr, input logic [7:0] dec_data);
    bit         fwd;
    bit         hs;
    int         cyc;
    int         beat;
    int         first;
    logic [3:0] pat;
    pat   = 4'b1001;
    fwd   = model_match(route);
    if (fwd) begin
      for (int b = 0; b < n; b++)
        exp_q.push_back('{data: DB'(base + b), last: (b == n - 1), port: route[1:0]});
      if (mfwd < CMAX) mfwd++;
    end else if (mdrop < CMAX) begin
      mdrop++;
    end
    if (dec_wr) model_cap(dec_data, 1'b1, 1'b0);
    s_route = route;
    cyc     = 0;
    beat    = 0;
    first   = -1;
    while (beat < n && cyc < 200) begin
      s_if.tvalid  = 1'b1;
      s_if.tdata   = DB'(base + beat);
      s_if.tkeep   = '1;
      s_if.tlast   = (beat == n - 1);
      cap_wr_valid = dec_wr && (cyc == 1);
      cap_wr_data  = dec_data;
      m_if.tready  = (stall && cyc >= 2 && cyc < 6) ? {NP{pat[cyc-2]}} : '1;
      @(negedge aclk);
      hs = s_if.tready[0];
      if (hs) begin
        if (first < 0) first = cyc;
        last_mvalid = m_if.tvalid;
        last_busy   = busy;
        if (!fwd) chk("drop_no_valid", DB'(m_if.tvalid), DB'(0));
      end
      @(posedge aclk); #1;
      if (hs) beat++;
      cyc++;
    end
    s_if.tvalid  = 1'b0;
    cap_wr_valid = 1'b0;
    m_if.tready  = '1;
    chk("beats_accepted", DB'(beat), DB'(n));
    chk("bubble_cycles", DB'(first), DB'(2));
    chk("busy_in_pkt", DB'(last_busy), DB'(1));
    @(negedge aclk);
    chk("exp_q_drained", DB'(exp_q.size()), DB'(0));
    chk("fwd_cnt", DB'(fwd_cnt), DB'(mfwd));
    chk("drop_cnt", DB'(drop_cnt), DB'(mdrop));
    chk("busy_idle", DB'(busy), DB'(0));
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit hs;
    int cyc;
    aresetn      = 1'b0;
    cap_wr_valid = 1'b0;
    cap_wr_data  = '0;
    cap_clr      = 1'b0;
    s_route      = '0;
    s_if.tvalid  = '0;
    s_if.tdata   = '0;
    s_if.tkeep   = '0;
    s_if.tlast   = 1'b0;
    m_if.tready  = '1;
    model_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tready", DB'(s_if.tready), DB'(0));
    chk("rst_tvalid", DB'(m_if.tvalid), DB'(0));
    chk("rst_fwd", DB'(fwd_cnt), DB'(0));
    chk("rst_drop", DB'(drop_cnt), DB'(0));
    chk("rst_busy", DB'(busy), DB'(0));
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // ul=3 port=1 -> forward on port 1
    cap_op(8'h0D, 1'b1, 1'b0);
    send_pkt(8'h0D, 4, 32'h100, 1'b0, 1'b0, 8'h00);
    chk("t1_valid_lit", DB'(last_mvalid), DB'(4'b0010));
    chk("t1_fwd_lit", DB'(fwd_cnt), DB'(1));
    chk("t1_drop_lit", DB'(drop_cnt), DB'(0));

    // ul=2 port=1 -> UL mismatch, dropped
    send_pkt(8'h09, 4, 32'h200, 1'b0, 1'b0, 8'h00);
    chk("t2_valid_lit", DB'(last_mvalid), DB'(4'b0000));
    chk("t2_drop_lit", DB'(drop_cnt), DB'(1));

    // port 2 never written; then clear (winning over a same-cycle write)
    send_pkt(8'h0E, 2, 32'h300, 1'b0, 1'b0, 8'h00);
    cap_op(8'h0D, 1'b1, 1'b1);
    send_pkt(8'h0D, 3, 32'h400, 1'b0, 1'b0, 8'h00);
    chk("t3_drop_lit", DB'(drop_cnt), DB'(3));
    chk("t3_fwd_lit", DB'(fwd_cnt), DB'(1));

    // port 0 with downstream ready 1,0,0,1
    cap_op(8'h04, 1'b1, 1'b0);
    send_pkt(8'h04, 4, 32'h500, 1'b1, 1'b0, 8'h00);
    chk("t4_fwd_lit", DB'(fwd_cnt), DB'(2));

    // write {ul=5,port=0} during decision: not seen now, seen next packet
    send_pkt(8'h14, 2, 32'h600, 1'b0, 1'b1, 8'h14);
    chk("t5a_drop_lit", DB'(drop_cnt), DB'(4));
    send_pkt(8'h14, 2, 32'h700, 1'b0, 1'b0, 8'h00);
    chk("t5b_valid_lit", DB'(last_mvalid), DB'(4'b0001));
    chk("t5b_fwd_lit", DB'(fwd_cnt), DB'(3));

    // single-beat drops push the narrow drop counter into saturation
    for (int i = 0; i < 5; i++) send_pkt(8'h0A, 1, 32'h800 + i, 1'b0, 1'b0, 8'h00);
    chk("sat_drop_lit", DB'(drop_cnt), DB'(7));

    // reset on beat 2 of a 5-beat forwarded packet
    cap_op(8'h0D, 1'b1, 1'b0);
    exp_q.push_back('{data: DB'(32'h900), last: 1'b0, port: 2'd1});
    exp_q.push_back('{data: DB'(32'h901), last: 1'b0, port: 2'd1});
    s_route     = 8'h0D;
    s_if.tvalid = 1'b1;
    s_if.tdata  = DB'(32'h900);
    s_if.tlast  = 1'b0;
    hs  = 1'b0;
    cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge aclk);
      hs = s_if.tready[0];
      @(posedge aclk); #1;
      cyc++;
    end
    chk("rst_pre_accept", DB'(hs), DB'(1));
    s_if.tdata = DB'(32'h901);
    aresetn    = 1'b0;
    @(negedge aclk);
    chk("rst_beat2_valid", DB'(m_if.tvalid), DB'(4'b0010));
    @(posedge aclk); #1;
    model_reset();
    s_if.tdata = DB'(32'h902);
    @(negedge aclk);
    chk("mid_rst_tvalid", DB'(m_if.tvalid), DB'(0));
    chk("mid_rst_tready", DB'(s_if.tready), DB'(0));
    chk("mid_rst_fwd", DB'(fwd_cnt), DB'(0));
    chk("mid_rst_drop", DB'(drop_cnt), DB'(0));
    chk("mid_rst_busy", DB'(busy), DB'(0));
    @(posedge aclk); #1;
    aresetn = 1'b1;
    send_pkt(8'h0D, 3, 32'h902, 1'b0, 1'b0, 8'h00);
    chk("post_rst_drop_lit", DB'(drop_cnt), DB'(1));
    chk("post_rst_fwd_lit", DB'(fwd_cnt), DB'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
